// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scanner for a 4-digit common-anode
// 7-segment display. A new value is taken into a shadow buffer and copied
// into the live display buffer only at a frame boundary. Each digit slot
// opens with an all-anodes-off guard interval to stop ghosting. Optional
// leading-zero blanking suppresses the upper zero digits.
module seg_scan_mux #(
  parameter int DIGIT_CYCLES = 3000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic        blank_lz,
  output logic [3:0]  bin,
  output logic [3:0]  digit_en_n,
  output logic        dp_n
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);

  // Scan position inside the frame.
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  // Shadow buffer holds an accepted value until the next frame boundary.
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;
  logic          pending;

  // Display buffer is what the scanner actually shows.
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;

  // Low during reset and on the first cycle after it, so that value_ready
  // is held low while rst_n is asserted.
  logic          live;

  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic          in_show;
  logic          digit_on;
  logic [3:0]    blanked;
  logic [3:0]    cur_nib;

  // Handshake: a transfer happens on a rising edge where value_valid and
  // value_ready are both high. value_ready is high exactly when the shadow
  // buffer is empty; the source must hold value_in/dp_in stable while
  // value_valid is high and value_ready is low.
  assign value_ready = live & ~pending;
  assign accept      = value_valid & value_ready;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign in_show   = (cnt >= GUARD_END);

  // Leading-zero blanking: digit i is dark when it and every digit above it
  // hold zero; digit 0 always shows so a zero value still displays "0".
  always_comb begin
    blanked    = 4'b0000;
    blanked[3] = blank_lz && (disp_val[15:12] == 4'h0);
    blanked[2] = blank_lz && (disp_val[15:8]  == 8'h00);
    blanked[1] = blank_lz && (disp_val[15:4]  == 12'h000);
  end

  // Nibble of the digit currently being scanned, and whether it lights up.
  always_comb begin
    cur_nib  = disp_val[{idx, 2'b00} +: 4];
    digit_on = in_show && !blanked[idx];
  end

  // Slot counter and digit index advance through the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Double buffer: accept into shadow, publish to display at the frame wrap.
  // An accept cannot collide with a publish because ready is low while
  // pending is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      pending    <= 1'b0;
      disp_val   <= 16'h0000;
      disp_dp    <= 4'h0;
    end else if (frame_end && pending) begin
      disp_val <= shadow_val;
      disp_dp  <= shadow_dp;
      pending  <= 1'b0;
    end else if (accept) begin
      shadow_val <= value_in;
      shadow_dp  <= dp_in;
      pending    <= 1'b1;
    end
  end

  // Tracks that at least one edge has passed with reset released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // Registered display outputs, one cycle behind the scan position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin        <= 4'h0;
      digit_en_n <= 4'b1111;
      dp_n       <= 1'b1;
    end else begin
      bin        <= cur_nib;
      digit_en_n <= digit_on ? ~(4'b0001 << idx) : 4'b1111;
      dp_n       <= digit_on ? ~disp_dp[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux with DIGIT_CYCLES=8, GUARD_CYCLES=2.
// A frame-position reference model predicts every registered output;
// predictions go into exp_q as stimulus is applied and are popped and
// compared once the DUT updates its outputs.
module tb_seg_scan_mux;

  localparam int DC = 8;
  localparam int G  = 2;
  localparam int FR = 4 * DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        value_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        value_ready;
  logic [3:0]  bin;
  logic [3:0]  digit_en_n;
  logic        dp_n;

  seg_scan_mux #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .blank_lz   (blank_lz),
    .bin        (bin),
    .digit_en_n (digit_en_n),
    .dp_n       (dp_n)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state: position in frame since reset, buffers.
  int          pos;
  bit          m_live;
  bit          m_pend;
  logic [19:0] m_shadow;
  logic [19:0] m_disp;
  int          last_c;

  // Scoreboard: {bin, digit_en_n, dp_n, value_ready}
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_v;
  logic [9:0]  got;
  int          n_checks = 0;
  int          n_fail = 0;

  // Driver: predicts the outputs for the next edge from the current inputs,
  // advances the model, then clocks the DUT and settles 1 time unit.
  task automatic drive_cycle();
    int c;
    int d;
    bit on;
    logic [3:0] nib;
    logic [3:0] en;
    logic dpv;
    bit rdy_now;
    bit acc;
    bit wrap;
    if (!rst_n) begin
      exp_q.push_back({4'h0, 4'hF, 1'b1, 1'b0});
      pos = 0; m_live = 0; m_pend = 0; m_shadow = '0; m_disp = '0; last_c = -1;
    end else begin
      c = pos % DC;
      d = (pos / DC) % 4;
      nib = m_disp[4*d +: 4];
      on = (c >= G) && !(d != 0 && blank_lz && ((m_disp[15:0] >> (4*d)) == 16'h0));
      en = on ? ~(4'b0001 << d) : 4'hF;
      dpv = on ? ~m_disp[16+d] : 1'b1;
      rdy_now = m_live && !m_pend;
      acc = value_valid && rdy_now;
      wrap = (c == DC-1) && (d == 3);
      if (wrap && m_pend) begin
        m_disp = m_shadow;
        m_pend = 0;
      end else if (acc) begin
        m_shadow = {dp_in, value_in};
        m_pend = 1;
      end
      m_live = 1;
      pos++;
      last_c = c;
      exp_q.push_back({nib, en, dpv, (m_live && !m_pend)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_state got=%b exp=%b", got, exp_v);
      end
    end
    rst_n = 1'b1;
    drive_cycle();
    exp_v = exp_q.pop_front();
    got = {bin, digit_en_n, dp_n, value_ready};
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", got, exp_v);
    end
    n_checks++;
    if (value_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release got=%b exp=1", value_ready);
    end
    repeat (2 * FR) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL idle_scan pos=%0d got=%b exp=%b", pos, got, exp_v);
      end
      n_checks++;
      if (bin !== 4'h0) begin
        n_fail++;
        $display("FAIL idle_bin got=%h exp=0", bin);
      end
    end
  endtask

  task automatic test_accept();
    int k;
    // Move to cnt=3 of digit 1
    for (k = 0; k < 100 && !((pos % DC) == 3 && ((pos / DC) % 4) == 1); k++) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL accept_wait got=%b exp=%b", got, exp_v);
      end
    end
    if (k >= 100) begin
      n_fail++;
      $display("FAIL accept_align timeout got=%0d exp=<100", k);
    end
    value_in = 16'h12A4;
    dp_in = 4'b0010;
    value_valid = 1'b1;
    drive_cycle();
    value_valid = 1'b0;
    value_in = 16'hDEAD;
    exp_v = exp_q.pop_front();
    got = {bin, digit_en_n, dp_n, value_ready};
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL accept_edge got=%b exp=%b", got, exp_v);
    end
    n_checks++;
    if (value_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_ready_drop got=%b exp=0", value_ready);
    end
    repeat (2 * FR) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL accept_scan pos=%0d got=%b exp=%b", pos, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit took;
    value_in = 16'h0001;
    dp_in = 4'h0;
    value_valid = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      took = 0;
      for (k = 0; k < 3 * FR && !took; k++) begin
        took = m_live && !m_pend;
        drive_cycle();
        exp_v = exp_q.pop_front();
        got = {bin, digit_en_n, dp_n, value_ready};
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_scan pos=%0d got=%b exp=%b", pos, got, exp_v);
        end
      end
      if (!took) begin
        n_fail++;
        $display("FAIL b2b_accept timeout got=%0d exp=<%0d", k, 3 * FR);
      end
      if (pass == 1) begin
        // The stalled value goes in one cycle after the frame transfer.
        n_checks++;
        if ((pos % FR) != 1) begin
          n_fail++;
          $display("FAIL b2b_stall_release got=%0d exp=1", pos % FR);
        end
      end
      value_in = 16'hFFFF;
    end
    value_valid = 1'b0;
    repeat (2 * FR) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_drain pos=%0d got=%b exp=%b", pos, got, exp_v);
      end
    end
  endtask

  task automatic test_blank();
    int k;
    logic [15:0] vals [2];
    logic [3:0]  dark [2];
    vals[0] = 16'h0050; dark[0] = 4'b1100;
    vals[1] = 16'h0000; dark[1] = 4'b1110;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      value_in = vals[v];
      dp_in = 4'h0;
      value_valid = 1'b1;
      // Offer, then wait for the frame transfer to clear pending.
      for (k = 0; k < 3 * FR && !(m_pend == 0 && value_valid == 0); k++) begin
        if (m_live && !m_pend && value_valid) begin
          drive_cycle();
          value_valid = 1'b0;
        end else begin
          drive_cycle();
        end
        exp_v = exp_q.pop_front();
        got = {bin, digit_en_n, dp_n, value_ready};
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL blank_load got=%b exp=%b", got, exp_v);
        end
      end
      if (k >= 3 * FR) begin
        n_fail++;
        $display("FAIL blank_load timeout got=%0d exp=<%0d", k, 3 * FR);
      end
      // One output update still reflects the old display.
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL blank_edge got=%b exp=%b", got, exp_v);
      end
      repeat (FR + 4) begin
        drive_cycle();
        exp_v = exp_q.pop_front();
        got = {bin, digit_en_n, dp_n, value_ready};
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL blank_scan v=%h got=%b exp=%b", vals[v], got, exp_v);
        end
        n_checks++;
        if ((~digit_en_n & dark[v]) !== 4'b0000) begin
          n_fail++;
          $display("FAIL blank_dark v=%h got=%b exp_dark=%b", vals[v], digit_en_n, dark[v]);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    bit took;
    value_in = 16'h1234;
    dp_in = 4'hF;
    value_valid = 1'b1;
    took = 0;
    for (k = 0; k < 3 * FR && !(m_pend && (pos % DC) == 5 && ((pos / DC) % 4) == 2); k++) begin
      took = m_live && !m_pend && value_valid;
      drive_cycle();
      if (took) value_valid = 1'b0;
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_wait got=%b exp=%b", got, exp_v);
      end
    end
    value_valid = 1'b0;
    if (k >= 3 * FR) begin
      n_fail++;
      $display("FAIL rstmid_align timeout got=%0d exp=<%0d", k, 3 * FR);
    end
    rst_n = 1'b0;
    drive_cycle();
    rst_n = 1'b1;
    exp_v = exp_q.pop_front();
    got = {bin, digit_en_n, dp_n, value_ready};
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL rstmid_state got=%b exp=%b", got, exp_v);
    end
    n_checks++;
    if (digit_en_n !== 4'b1111 || value_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got=%b/%b exp=1111/0", digit_en_n, value_ready);
    end
    repeat (FR + 4) begin
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_scan pos=%0d got=%b exp=%b", pos, got, exp_v);
      end
      n_checks++;
      if (bin !== 4'h0 || dp_n !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_cleared got=%h/%b exp=0/1", bin, dp_n);
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      value_in = 16'($urandom_range(0, 65535));
      dp_in = 4'($urandom_range(0, 15));
      value_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 3) == 0) value_in[15:8] = 8'h00;
      drive_cycle();
      exp_v = exp_q.pop_front();
      got = {bin, digit_en_n, dp_n, value_ready};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL random_scan pos=%0d got=%b exp=%b", pos, got, exp_v);
      end
      n_checks++;
      if ($countones(~digit_en_n) > 1) begin
        n_fail++;
        $display("FAIL random_onehot got=%b exp=at_most_one_low", digit_en_n);
      end
      n_checks++;
      if (last_c >= 0 && last_c < G && digit_en_n !== 4'b1111) begin
        n_fail++;
        $display("FAIL random_guard slot_cnt=%0d got=%b exp=1111", last_c, digit_en_n);
      end
    end
    value_valid = 1'b0;
    blank_lz = 1'b0;
  endtask

  initial begin
    test_reset();
    test_accept();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
